// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one 64-bit add/sub datapath.
// A request is granted in IDLE, its operands are latched, the add/sub runs
// for one cycle in EXEC, and the registered result with Y86 flags (ZF/SF/OF)
// and owner ID is presented in RESP until the consumer takes it.

// add_sub_64bit: two's complement adder/subtractor with signed-overflow flag.
// Subtraction is A + ~B + 1. Overflow is the carry into bit 63 XOR the carry
// out of bit 63, so bit 63 is summed separately to expose both carries.
module add_sub_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sub,
    output logic [63:0] sum,
    output logic        of
);

    logic [63:0] b_eff;
    logic [63:0] low_sum;
    logic        carry_into_msb;
    logic        carry_out_msb;

    // Ripple the low 63 bits with the subtract carry-in, then form bit 63 and both carries.
    always_comb begin
        b_eff          = sub ? ~b : b;
        low_sum        = {1'b0, a[62:0]} + {1'b0, b_eff[62:0]} + {63'd0, sub};
        carry_into_msb = low_sum[63];
        carry_out_msb  = (a[63] & b_eff[63]) | (carry_into_msb & (a[63] ^ b_eff[63]));
        sum            = {a[63] ^ b_eff[63] ^ carry_into_msb, low_sum[62:0]};
        of             = carry_into_msb ^ carry_out_msb;
    end

endmodule

module alu_share_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_sub,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_of,
    output logic        rsp_zf,
    output logic        rsp_sf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;

    logic [63:0] op_a_q, op_a_d;
    logic [63:0] op_b_q, op_b_d;
    logic        op_sub_q, op_sub_d;
    logic        op_id_q, op_id_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [63:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_of_q, rsp_of_d;
    logic        rsp_zf_q, rsp_zf_d;
    logic        rsp_sf_q, rsp_sf_d;

    logic        grant;
    logic        handshake;
    logic [63:0] add_sum;
    logic        add_of;

    // The shared datapath only ever sees the latched operands, so requester
    // inputs changing after acceptance cannot disturb an in-flight result.
    add_sub_64bit u_add_sub (
        .a   (op_a_q),
        .b   (op_b_q),
        .sub (op_sub_q),
        .sum (add_sum),
        .of  (add_of)
    );

    // Pick the winner: a lone requester wins; on a tie round-robin favours the
    // one not served last, fixed priority always favours requester 0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FAIR != 0) ? ~last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is only offered in IDLE and only to the winner, so at most one fires.
    always_comb begin
        req0_ready = (state_q == IDLE) && req0_valid && !grant;
        req1_ready = (state_q == IDLE) && req1_valid && grant;
        handshake  = req0_ready || req1_ready;
    end

    // Next-state and next-value logic for the FSM, operand latch and response registers.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sub_d     = op_sub_q;
        op_id_d      = op_id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_of_d     = rsp_of_q;
        rsp_zf_d     = rsp_zf_q;
        rsp_sf_d     = rsp_sf_q;

        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    state_d      = EXEC;
                    op_a_d       = grant ? req1_a : req0_a;
                    op_b_d       = grant ? req1_b : req0_b;
                    op_sub_d     = grant ? req1_sub : req0_sub;
                    op_id_d      = grant;
                    last_grant_d = grant;
                end
            end
            EXEC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_sum_d   = add_sum;
                rsp_of_d    = add_of;
                rsp_zf_d    = (add_sum == 64'd0);
                rsp_sf_d    = add_sum[63];
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // All state registers; a synchronous reset discards any in-flight transaction
    // and re-arms the arbiter so requester 0 wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= 64'd0;
            op_b_q       <= 64'd0;
            op_sub_q     <= 1'b0;
            op_id_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_sum_q    <= 64'd0;
            rsp_of_q     <= 1'b0;
            rsp_zf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sub_q     <= op_sub_d;
            op_id_q      <= op_id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_of_q     <= rsp_of_d;
            rsp_zf_q     <= rsp_zf_d;
            rsp_sf_q     <= rsp_sf_d;
        end
    end

    // Response outputs come straight from registers; busy reflects the FSM leaving IDLE.
    always_comb begin
        rsp_valid = rsp_valid_q;
        rsp_id    = rsp_id_q;
        rsp_sum   = rsp_sum_q;
        rsp_of    = rsp_of_q;
        rsp_zf    = rsp_zf_q;
        rsp_sf    = rsp_sf_q;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared add/sub
// arbiter against a behavioural model (wide signed arithmetic for results,
// a phase counter for the accept/execute/respond timeline).
module tb_alu_share_arbiter;

    logic        clk, rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic        req1_valid, req1_ready, req1_sub;
    logic [63:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_of, rsp_zf, rsp_sf, busy;
    logic [63:0] rsp_sum;

    logic        f0_valid, f0_ready, f0_sub;
    logic        f1_valid, f1_ready, f1_sub;
    logic [63:0] f0_a, f0_b, f1_a, f1_b;
    logic        f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_of, f_rsp_zf, f_rsp_sf, f_busy;
    logic [63:0] f_rsp_sum;

    typedef struct packed {
        logic [63:0] sum;
        logic        of;
        logic        zf;
        logic        sf;
    } res_t;

    int   nChecks = 0;
    int   nFail   = 0;
    int   phase;
    bit   lastGrant;
    bit   expId;
    res_t expRes;
    bit   obsLog[$];

    alu_share_arbiter #(.FAIR(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_of(rsp_of), .rsp_zf(rsp_zf), .rsp_sf(rsp_sf), .busy(busy)
    );

    alu_share_arbiter #(.FAIR(0)) dut_fixed (
        .clk(clk), .rst(rst),
        .req0_valid(f0_valid), .req0_ready(f0_ready), .req0_a(f0_a), .req0_b(f0_b), .req0_sub(f0_sub),
        .req1_valid(f1_valid), .req1_ready(f1_ready), .req1_a(f1_a), .req1_b(f1_b), .req1_sub(f1_sub),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id), .rsp_sum(f_rsp_sum),
        .rsp_of(f_rsp_of), .rsp_zf(f_rsp_zf), .rsp_sf(f_rsp_sf), .busy(f_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result: exact signed arithmetic in 65 bits, overflow when it does not fit in 64.
    function automatic res_t refModel(input logic [63:0] a, input logic [63:0] b, input logic sub);
        res_t r;
        logic signed [64:0] wa, wb, w;
        wa = $signed({a[63], a});
        wb = $signed({b[63], b});
        w  = sub ? (wa - wb) : (wa + wb);
        r.sum = w[63:0];
        r.of  = (w[64] != w[63]);
        r.zf  = (w[63:0] == 64'd0);
        r.sf  = w[63];
        return r;
    endfunction

    function automatic logic [63:0] randOp();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            3:       v = 64'($urandom_range(0, 3));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scrambleOps();
        req0_a = randOp(); req0_b = randOp(); req0_sub = 1'($urandom_range(0, 1));
        req1_a = randOp(); req1_b = randOp(); req1_sub = 1'($urandom_range(0, 1));
    endtask

    task automatic resetModel();
        phase     = 0;
        lastGrant = 1'b1;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_id"}, rsp_id, 0);
        checkOutput({tag, "_rsp_sum"}, rsp_sum, 0);
        checkOutput({tag, "_rsp_of"}, rsp_of, 0);
        checkOutput({tag, "_rsp_zf"}, rsp_zf, 0);
        checkOutput({tag, "_rsp_sf"}, rsp_sf, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    task automatic applyReset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
    endtask

    // One clock of the FAIR=1 instance: check outputs at the falling edge, then advance the model.
    task automatic stepCycle(output bit hs0, output bit hs1);
        bit   winner, retire;
        res_t cand;
        @(negedge clk);
        winner = 1'b0;
        if (req0_valid && req1_valid) winner = !lastGrant;
        else if (req1_valid)          winner = 1'b1;
        hs0 = (phase == 0) && req0_valid && !winner;
        hs1 = (phase == 0) && req1_valid && winner;
        if (req0_ready || req1_ready) obsLog.push_back(req1_ready);
        checkOutput("req0_ready", req0_ready, hs0);
        checkOutput("req1_ready", req1_ready, hs1);
        checkOutput("busy", busy, phase != 0);
        checkOutput("rsp_valid", rsp_valid, phase == 2);
        if (phase == 2) begin
            checkOutput("rsp_sum", rsp_sum, expRes.sum);
            checkOutput("rsp_of", rsp_of, expRes.of);
            checkOutput("rsp_zf", rsp_zf, expRes.zf);
            checkOutput("rsp_sf", rsp_sf, expRes.sf);
            checkOutput("rsp_id", rsp_id, expId);
        end
        retire = (phase == 2) && rsp_ready;
        cand   = winner ? refModel(req1_a, req1_b, req1_sub) : refModel(req0_a, req0_b, req0_sub);
        @(posedge clk);
        if (hs0 || hs1) begin
            phase     = 1;
            lastGrant = winner;
            expId     = winner;
            expRes    = cand;
        end else if (phase == 1) begin
            phase = 2;
        end else if (retire) begin
            phase = 0;
        end
        #1;
    endtask

    task automatic drain();
        bit h0, h1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 6 && phase != 0; i++) stepCycle(h0, h1);
        checkOutput("drain_idle", busy, 0);
    endtask

    // A single isolated operation with spec-given expected values checked while in RESP.
    task automatic directedOp(input string tag, input bit id, input logic [63:0] a, input logic [63:0] b,
                              input bit sub, input logic [63:0] eSum, input bit eOf, input bit eZf, input bit eSf);
        bit h0, h1;
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end
        stepCycle(h0, h1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        scrambleOps();
        stepCycle(h0, h1);
        checkOutput({tag, "_valid"}, rsp_valid, 1);
        checkOutput({tag, "_sum"}, rsp_sum, eSum);
        checkOutput({tag, "_of"}, rsp_of, eOf);
        checkOutput({tag, "_zf"}, rsp_zf, eZf);
        checkOutput({tag, "_sf"}, rsp_sf, eSf);
        checkOutput({tag, "_id"}, rsp_id, id);
        stepCycle(h0, h1);
        stepCycle(h0, h1);
    endtask

    // Random requester behaviour that respects hold-until-ready.
    task automatic applyStimulus(input bit h0, input bit h1);
        if (!req0_valid || h0) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a = randOp(); req0_b = randOp(); req0_sub = 1'($urandom_range(0, 1));
        end
        if (!req1_valid || h1) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a = randOp(); req1_b = randOp(); req1_sub = 1'($urandom_range(0, 1));
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        bit   h0, h1, hsF;
        int   fPhase;
        res_t fExp;

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        f0_valid = 1'b0; f1_valid = 1'b0; f_rsp_ready = 1'b0;
        f0_a = '0; f0_b = '0; f0_sub = 1'b0;
        f1_a = '0; f1_b = '0; f1_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resetModel();
        checkResetState("reset");
        checkOutput("reset_fixed_valid", f_rsp_valid, 0);
        checkOutput("reset_fixed_busy", f_busy, 0);

        $display("[TB] directed add/sub/overflow cases");
        directedOp("add5_7",   1'b0, 64'd5, 64'd7, 1'b0, 64'd12, 1'b0, 1'b0, 1'b0);
        directedOp("sub9_9",   1'b1, 64'd9, 64'd9, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0);
        directedOp("sub3_10",  1'b1, 64'd3, 64'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 1'b1);
        directedOp("ovf_add",  1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        directedOp("ovf_sub",  1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        directedOp("wrap_add", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] round-robin contention");
        obsLog.delete();
        rsp_ready = 1'b1;
        scrambleOps();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 0; c < 40 && obsLog.size() < 6; c++) begin
            stepCycle(h0, h1);
            if (h0) begin req0_a = randOp(); req0_b = randOp(); req0_sub = 1'($urandom_range(0, 1)); end
            if (h1) begin req1_a = randOp(); req1_b = randOp(); req1_sub = 1'($urandom_range(0, 1)); end
        end
        checkOutput("rr_grant_count", obsLog.size(), 6);
        for (int k = 0; k < obsLog.size(); k++) checkOutput($sformatf("rr_grant%0d", k), obsLog[k], k % 2);
        drain();

        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 64'd100; req0_b = 64'd58; req0_sub = 1'b1;
        stepCycle(h0, h1);
        req0_valid = 1'b0;
        stepCycle(h0, h1);
        scrambleOps();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            stepCycle(h0, h1);
            checkOutput($sformatf("bp_sum%0d", i), rsp_sum, 64'd42);
        end
        rsp_ready = 1'b1;
        stepCycle(h0, h1);
        stepCycle(h0, h1);
        checkOutput("bp_next_accepted", busy, 1);
        drain();

        $display("[TB] reset during EXEC");
        req0_valid = 1'b1; req0_a = 64'd1; req0_b = 64'd2; req0_sub = 1'b0;
        stepCycle(h0, h1);
        req0_valid = 1'b0;
        applyReset();
        checkResetState("rst_exec");
        stepCycle(h0, h1);
        stepCycle(h0, h1);

        $display("[TB] reset during RESP");
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 64'd20; req1_b = 64'd22; req1_sub = 1'b0;
        stepCycle(h0, h1);
        req1_valid = 1'b0;
        stepCycle(h0, h1);
        checkOutput("rst_resp_pre_valid", rsp_valid, 1);
        applyReset();
        checkResetState("rst_resp");
        stepCycle(h0, h1);
        scrambleOps();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput("tie_after_reset_r0", req0_ready, 1);
        checkOutput("tie_after_reset_r1", req1_ready, 0);
        rsp_ready = 1'b1;
        stepCycle(h0, h1);
        drain();

        $display("[TB] randomized traffic");
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) begin
            stepCycle(h0, h1);
            applyStimulus(h0, h1);
        end
        drain();

        $display("[TB] fixed-priority contention");
        f_rsp_ready = 1'b1;
        f0_valid = 1'b1; f0_a = randOp(); f0_b = randOp(); f0_sub = 1'($urandom_range(0, 1));
        f1_valid = 1'b1; f1_a = randOp(); f1_b = randOp(); f1_sub = 1'($urandom_range(0, 1));
        fPhase = 0;
        fExp   = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checkOutput("fixed_req0_ready", f0_ready, fPhase == 0);
            checkOutput("fixed_req1_ready", f1_ready, 0);
            checkOutput("fixed_rsp_valid", f_rsp_valid, fPhase == 2);
            if (fPhase == 2) begin
                checkOutput("fixed_rsp_id", f_rsp_id, 0);
                checkOutput("fixed_rsp_sum", f_rsp_sum, fExp.sum);
                checkOutput("fixed_rsp_of", f_rsp_of, fExp.of);
            end
            hsF = (fPhase == 0);
            if (hsF) fExp = refModel(f0_a, f0_b, f0_sub);
            @(posedge clk);
            #1;
            if (hsF) begin
                fPhase = 1;
                f0_a = randOp(); f0_b = randOp(); f0_sub = 1'($urandom_range(0, 1));
            end else if (fPhase == 1) begin
                fPhase = 2;
            end else begin
                fPhase = 0;
            end
        end
        f0_valid = 1'b0;
        f1_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
